// File: rtl/uart_receiver_if.sv
// Serial receiver link bundle: line configuration and Rx in, received byte and status out.
// The master side drives the line and its settings; the slave side is the receiver.
interface uart_receiver_if;
  logic [1:0] BaudRate;
  logic [1:0] ParityMode;
  logic       StopBits;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxValid;
  logic       ParityErr;
  logic       FrameErr;
  logic       RxBusy;

  modport master (
    output BaudRate, ParityMode, StopBits, Rx,
    input  RxData, RxValid, ParityErr, FrameErr, RxBusy
  );

  modport slave (
    input  BaudRate, ParityMode, StopBits, Rx,
    output RxData, RxValid, ParityErr, FrameErr, RxBusy
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampling with a 3-sample mid-bit majority vote, optional parity,
// one or two stop bits, and a single-cycle delivery strobe carrying parity/framing status.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, watching for a 1->0 edge
// START     | confirm the start bit at mid-bit (a high vote means glitch)
// DATA      | shift in 8 data bits, LSB first
// PARITY    | check the parity bit against the received data
// STOP1     | first stop bit; delivers the frame unless two stop bits are set
// STOP2     | second stop bit; delivers the frame
// WAIT_HIGH | framing error seen, hold off until the line returns high
module uart_receiver #(
  parameter int unsigned DIV_0 = 326,
  parameter int unsigned DIV_1 = 163,
  parameter int unsigned DIV_2 = 54,
  parameter int unsigned DIV_3 = 27
) (
  input  logic            CLK,
  input  logic            RST,
  uart_receiver_if.slave  rx_if
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
  } state_t;

  state_t     state_q, state_d;
  logic       rx_meta_q, rx_meta_d;
  logic       rx_sync_q, rx_sync_d;
  logic       rx_prev_q, rx_prev_d;
  logic [8:0] div_cnt_q, div_cnt_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       s6_q, s6_d;
  logic       s7_q, s7_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic [1:0] baud_q, baud_d;
  logic [1:0] pmode_q, pmode_d;
  logic       stop2_q, stop2_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  logic [8:0] div_reload;
  logic       tick;
  logic       mid;
  logic       vote;
  logic       ferr_now;

  always_comb begin
    div_reload = 9'(DIV_3 - 1);
    case (baud_q)
      2'b00:   div_reload = 9'(DIV_0 - 1);
      2'b01:   div_reload = 9'(DIV_1 - 1);
      2'b10:   div_reload = 9'(DIV_2 - 1);
      default: div_reload = 9'(DIV_3 - 1);
    endcase
  end

  // Majority of the count-6, count-7 and current (count-8) samples.
  assign vote = (s6_q & s7_q) | (s6_q & rx_sync_q) | (s7_q & rx_sync_q);

  always_comb begin
    rx_meta_d    = rx_if.Rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    s6_d         = s6_q;
    s7_d         = s7_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    baud_d       = baud_q;
    pmode_d      = pmode_q;
    stop2_d      = stop2_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    tick         = 1'b0;
    mid          = 1'b0;
    ferr_now     = ferr_q | ~vote;

    if (state_q != IDLE) begin
      if (div_cnt_q == 9'd0) begin
        tick      = 1'b1;
        div_cnt_d = div_reload;
      end else begin
        div_cnt_d = div_cnt_q - 9'd1;
      end
    end

    if (tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == 4'd6) s6_d = rx_sync_q;
      if (tick_cnt_q == 4'd7) s7_d = rx_sync_q;
      mid = (tick_cnt_q == 4'd8);
    end

    case (state_q)
      IDLE: begin
        div_cnt_d = 9'd0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
          bit_idx_d  = 3'd0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          baud_d     = rx_if.BaudRate;
          pmode_d    = rx_if.ParityMode;
          stop2_d    = rx_if.StopBits;
        end
      end
      START: begin
        if (mid) begin
          state_d   = vote ? IDLE : DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (mid) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = pmode_q[1] ? STOP1 : PARITY;
        end
      end
      PARITY: begin
        if (mid) begin
          if (vote != (^shift_q ^ pmode_q[0])) perr_d = 1'b1;
          state_d = STOP1;
        end
      end
      STOP1, STOP2: begin
        if (mid) begin
          ferr_d = ferr_now;
          if (state_q == STOP1 && stop2_q) begin
            state_d = STOP2;
          end else begin
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            rx_valid_d   = 1'b1;
            state_d      = ferr_now ? WAIT_HIGH : IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_cnt_q    <= 9'd0;
      tick_cnt_q   <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      s6_q         <= 1'b1;
      s7_q         <= 1'b1;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      baud_q       <= 2'b00;
      pmode_q      <= 2'b00;
      stop2_q      <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      s6_q         <= s6_d;
      s7_q         <= s7_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      baud_q       <= baud_d;
      pmode_q      <= pmode_d;
      stop2_q      <= stop2_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_if.RxData    = rx_data_q;
  assign rx_if.RxValid   = rx_valid_q;
  assign rx_if.ParityErr = parity_err_q;
  assign rx_if.FrameErr  = frame_err_q;
  assign rx_if.RxBusy    = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at BaudRate=11 (432-CLK bit period at 16 x 27).
// Each task drives one scenario and checks its own hand-computed expectations.
module tb_uart_receiver;
  localparam int BP = 432;

  logic CLK;
  logic RST;
  uart_receiver_if ifc ();

  uart_receiver dut (
    .CLK   (CLK),
    .RST   (RST),
    .rx_if (ifc)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int unsigned t_valid = 0;
  int          valid_cnt = 0;
  logic [7:0]  got_data[$];
  logic        got_perr[$];
  logic        got_ferr[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (ifc.RxValid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      t_valid   = cyc;
      got_data.push_back(ifc.RxData);
      got_perr.push_back(ifc.ParityErr);
      got_ferr.push_back(ifc.FrameErr);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // par < 0 means no parity bit on the line
  task automatic send_frame(input logic [7:0] d, input int par, input logic st1,
                            input logic two, input logic st2, input int bp);
    ifc.Rx  = 1'b0;
    t_start = cyc;
    idle(bp);
    for (int i = 0; i < 8; i++) begin
      ifc.Rx = d[i];
      idle(bp);
    end
    if (par >= 0) begin
      ifc.Rx = par[0];
      idle(bp);
    end
    ifc.Rx = st1;
    idle(bp);
    if (two) begin
      ifc.Rx = st2;
      idle(bp);
    end
    ifc.Rx = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    idle(5);
    checks++; if (ifc.RxData !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", ifc.RxData); end
    checks++; if (ifc.RxValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.RxValid); end
    checks++; if (ifc.ParityErr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", ifc.ParityErr); end
    checks++; if (ifc.FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ifc.FrameErr); end
    checks++; if (ifc.RxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.RxBusy); end
    RST = 1'b0;
    idle(20);
  endtask

  task automatic test_basic;
    int n0;
    int lat;
    n0 = valid_cnt;
    ifc.ParityMode = 2'b10;
    ifc.StopBits   = 1'b0;
    send_frame(8'hA5, -1, 1'b1, 1'b0, 1'b1, BP);
    idle(300);
    lat = int'(t_valid) - int'(t_start);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL basic_count got %0d exp %0d", valid_cnt - n0, 1); end
    checks++; if (got_data[$] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", got_data[$]); end
    checks++; if (got_perr[$] !== 1'b0) begin errors++; $display("FAIL basic_perr got %b exp 0", got_perr[$]); end
    checks++; if (got_ferr[$] !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", got_ferr[$]); end
    checks++; if (lat < 9 * BP + 150 || lat > 9 * BP + 300) begin errors++; $display("FAIL basic_latency got %0d exp about %0d", lat, 9 * BP + 220); end
    checks++; if (ifc.RxBusy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %b exp 0", ifc.RxBusy); end
  endtask

  task automatic test_parity;
    int n0;
    n0 = valid_cnt;
    ifc.ParityMode = 2'b00;
    send_frame(8'h07, 1, 1'b1, 1'b0, 1'b1, BP);
    idle(300);
    checks++; if (got_perr[$] !== 1'b0) begin errors++; $display("FAIL even_good_perr got %b exp 0", got_perr[$]); end
    send_frame(8'h07, 0, 1'b1, 1'b0, 1'b1, BP);
    idle(300);
    checks++; if (got_perr[$] !== 1'b1) begin errors++; $display("FAIL even_bad_perr got %b exp 1", got_perr[$]); end
    checks++; if (got_data[$] !== 8'h07) begin errors++; $display("FAIL even_bad_data got %h exp 07", got_data[$]); end
    ifc.ParityMode = 2'b01;
    send_frame(8'h07, 0, 1'b1, 1'b0, 1'b1, BP);
    idle(300);
    checks++; if (got_perr[$] !== 1'b0) begin errors++; $display("FAIL odd_good_perr got %b exp 0", got_perr[$]); end
    checks++; if (valid_cnt !== n0 + 3) begin errors++; $display("FAIL parity_count got %0d exp 3", valid_cnt - n0); end
    ifc.ParityMode = 2'b10;
  endtask

  task automatic test_stop2;
    int n0;
    ifc.StopBits = 1'b1;
    n0 = valid_cnt;
    send_frame(8'h3C, -1, 1'b1, 1'b1, 1'b0, BP);
    idle(300);
    checks++; if (got_ferr[$] !== 1'b1) begin errors++; $display("FAIL stop2_ferr got %b exp 1", got_ferr[$]); end
    checks++; if (got_data[$] !== 8'h3C) begin errors++; $display("FAIL stop2_data got %h exp 3c", got_data[$]); end
    idle(3000);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL stop2_quiet got %0d exp 1", valid_cnt - n0); end
    send_frame(8'h11, -1, 1'b1, 1'b1, 1'b1, BP);
    idle(300);
    checks++; if (got_ferr[$] !== 1'b0) begin errors++; $display("FAIL stop2_good_ferr got %b exp 0", got_ferr[$]); end
    checks++; if (got_data[$] !== 8'h11) begin errors++; $display("FAIL stop2_good_data got %h exp 11", got_data[$]); end
    ifc.StopBits = 1'b0;
  endtask

  task automatic test_glitch_break;
    int n0;
    n0 = valid_cnt;
    ifc.Rx = 1'b0;
    idle(81);
    ifc.Rx = 1'b1;
    idle(20);
    checks++; if (ifc.RxBusy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", ifc.RxBusy); end
    idle(200);
    checks++; if (ifc.RxBusy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got %b exp 0", ifc.RxBusy); end
    checks++; if (valid_cnt !== n0) begin errors++; $display("FAIL glitch_strobe got %0d exp 0", valid_cnt - n0); end
    ifc.Rx = 1'b0;
    idle(20 * BP);
    ifc.Rx = 1'b1;
    idle(2000);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL break_count got %0d exp 1", valid_cnt - n0); end
    checks++; if (got_data[$] !== 8'h00) begin errors++; $display("FAIL break_data got %h exp 00", got_data[$]); end
    checks++; if (got_ferr[$] !== 1'b1) begin errors++; $display("FAIL break_ferr got %b exp 1", got_ferr[$]); end
    checks++; if (ifc.RxBusy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", ifc.RxBusy); end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = valid_cnt;
    send_frame(8'h55, -1, 1'b1, 1'b0, 1'b1, 441);
    send_frame(8'hAA, -1, 1'b1, 1'b0, 1'b1, 423);
    idle(500);
    checks++; if (valid_cnt !== n0 + 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", valid_cnt - n0);
    end else begin
      checks++; if (got_data[n0] !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", got_data[n0]); end
      checks++; if (got_data[n0+1] !== 8'hAA) begin errors++; $display("FAIL b2b_second got %h exp aa", got_data[n0+1]); end
      checks++; if ((got_ferr[n0] | got_ferr[n0+1] | got_perr[n0] | got_perr[n0+1]) !== 1'b0) begin
        errors++; $display("FAIL b2b_errflags got %b%b%b%b exp 0000", got_ferr[n0], got_ferr[n0+1], got_perr[n0], got_perr[n0+1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = valid_cnt;
    ifc.Rx = 1'b0;
    idle(BP);
    ifc.Rx = 1'b1;
    idle(4 * BP + BP / 2);
    RST = 1'b1;
    idle(2);
    checks++; if (ifc.RxBusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", ifc.RxBusy); end
    checks++; if (ifc.RxData !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", ifc.RxData); end
    RST = 1'b0;
    idle(BP / 2 + 4 * BP);
    checks++; if (valid_cnt !== n0) begin errors++; $display("FAIL rstmid_nostrobe got %0d exp 0", valid_cnt - n0); end
    send_frame(8'h12, -1, 1'b1, 1'b0, 1'b1, BP);
    idle(300);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", valid_cnt - n0); end
    checks++; if (got_data[$] !== 8'h12) begin errors++; $display("FAIL rstmid_next got %h exp 12", got_data[$]); end
  endtask

  task automatic test_baud_change;
    int n0;
    n0 = valid_cnt;
    ifc.BaudRate = 2'b11;
    fork
      send_frame(8'h3A, -1, 1'b1, 1'b0, 1'b1, BP);
      begin
        idle(600);
        ifc.BaudRate = 2'b00;
      end
    join
    idle(300);
    checks++; if (valid_cnt !== n0 + 1) begin errors++; $display("FAIL baudchg_count got %0d exp 1", valid_cnt - n0); end
    checks++; if (got_data[$] !== 8'h3A) begin errors++; $display("FAIL baudchg_data got %h exp 3a", got_data[$]); end
    ifc.BaudRate = 2'b11;
    idle(20);
  endtask

  initial begin
    RST            = 1'b1;
    ifc.Rx         = 1'b1;
    ifc.BaudRate   = 2'b11;
    ifc.ParityMode = 2'b10;
    ifc.StopBits   = 1'b0;
    @(negedge CLK);
    test_reset;
    test_basic;
    test_parity;
    test_stop2;
    test_glitch_break;
    test_back_to_back;
    test_reset_mid;
    test_baud_change;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; pairs with the team's UART transmitter on the same link settings (BaudRate, ParityMode, StopBits encodings identical).
- Samples the asynchronous Rx line at 16x the bit rate and mid-bit votes each bit.
- Delivers each 8-bit frame with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- DIV_0, 326, CLK cycles per 16x sample tick for BaudRate=00 (9600 baud at 50 MHz).
- DIV_1, 163, CLK cycles per sample tick for BaudRate=01 (19200).
- DIV_2, 54, CLK cycles per sample tick for BaudRate=10 (57600).
- DIV_3, 27, CLK cycles per sample tick for BaudRate=11 (115200).

Ports:
- CLK  in  1  system clock; reset RST, asynchronous, active-high; clock CLK.
- RST  in  1  asynchronous active-high reset.
- BaudRate  in  2  selects DIV_0..DIV_3.
- ParityMode  in  2  00 even, 01 odd, 1X no parity.
- StopBits  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- Rx  in  1  serial line, asynchronous, idle high.
- RxData  out  8  last received byte, LSB first on the line.
- RxValid  out  1  one-CLK pulse when RxData and the error flags are updated.
- ParityErr  out  1  parity mismatch on the frame just delivered.
- FrameErr  out  1  a stop bit sampled low on the frame just delivered.
- RxBusy  out  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset: RxData=0x00, RxValid=0, ParityErr=0, FrameErr=0, RxBusy=0, state IDLE, synchronizer flops=1.
- Rx passes through a 2-FF synchronizer. All references to "Rx" below mean the synchronized value.
- Tick generator: counter reloads to DIV-1 and emits a tick when it hits 0. The counter is cleared on start-edge detection so ticks align to the edge.
- BaudRate, ParityMode and StopBits are latched at start detection and held for the whole frame. Mid-frame changes do not affect the frame in progress.
- Per-bit tick counter (4 bits) counts 0..15. A bit is sampled when the count reaches 7 (mid-bit), using a majority vote of the counts 6, 7 and 8 samples. The decision is applied at count 8.
- States:
  - IDLE: wait for a 1->0 transition of Rx, then go to START.
  - START: at mid-bit, if the voted value is 1 (glitch), go to IDLE with no strobe. Otherwise go to DATA with bit index 0.
  - DATA: 8 bits, one per 16 ticks, shifted in LSB first. After bit 7, go to PARITY if ParityMode[1]=0, otherwise go to STOP1.
  - PARITY: even mode expects XOR(data). Odd mode expects ~XOR(data). Mismatch sets the internal perr. Then go to STOP1.
  - STOP1: voted 0 sets the internal ferr. If StopBits=1, go to STOP2; otherwise deliver.
  - STOP2: voted 0 sets ferr, then deliver.
- Deliver:
  - On the CLK of the final stop-bit decision (mid-bit), register RxData, ParityErr=perr, FrameErr=ferr, and pulse RxValid for exactly 1 CLK.
  - Data is delivered even when an error flag is set.
  - The flags hold until the next RxValid.
  - If ferr=1, go to WAIT_HIGH; otherwise go to IDLE. This allows resync on a back-to-back start edge half a bit later.
- WAIT_HIGH: stay until Rx=1 for one CLK, then go to IDLE. A break (line held low) yields exactly one RxValid with RxData=0x00, FrameErr=1, and no further frames until the line returns high.
- RxBusy=1 in every state except IDLE.
- RST asserted mid-frame returns everything to reset values immediately. No partial frame is delivered after RST deasserts.
- With no parity, ParityErr is always 0 on delivery.

Test Plan:
- BaudRate=11, parity none, 1 stop. Send 0xA5 with a 432-CLK bit period -> one RxValid pulse, RxData=0xA5, ParityErr=0, FrameErr=0, pulse about 9.5 bit times after the start edge.
- ParityMode=00, send 0x07 with parity bit 1 -> ParityErr=0. Repeat with parity bit 0 -> ParityErr=1, RxData=0x07. ParityMode=01 with 0x07 and parity bit 0 -> ParityErr=0.
- StopBits=1. Send 0x3C with the second stop bit low -> FrameErr=1, RxData=0x3C. Then hold Rx high -> no new RxValid. The next good frame 0x11 -> FrameErr=0.
- Low glitch on idle Rx of 3 ticks (81 CLK) -> no RxValid, RxBusy returns to 0 at mid-start. Line held low for 20 bit times -> exactly one RxValid with RxData=0x00 and FrameErr=1.
- Back-to-back frames 0x55, 0xAA with no idle gap, each at ±2% bit-period skew -> two strobes with the correct bytes and no errors.
- Assert RST during data bit 4 of 0xFF, then send 0x12 -> no strobe for 0xFF, a single strobe with RxData=0x12. Change BaudRate mid-frame -> the current frame is still received correctly.
